chunked_tree_subtractor: RTL and testbench

- Multi-cycle wide subtractor. Computes difference = operand_1 - operand_2 - borrow_in on N_BIT-wide two's-complement or unsigned operands.
- Processes one CHUNK-bit slice per cycle, least-significant slice first, through a single CHUNK-wide parallel-prefix carry tree. The slice datapath is the adder with operand_2 inverted; the inter-chunk carry is registered.
- Sits beside the combinational tree adders. Intended for wide datapaths where a full-width prefix tree cannot meet area or timing.
- Valid/ready handshake on both input and output.

---
 rtl/chunked_tree_subtractor.sv | 146 ++++++++++++++
 tb/tb_chunked_tree_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_tree_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : chunked_tree_subtractor
// Description : Multi-cycle wide subtractor. Computes
//               difference = operand_1 - operand_2 - borrow_in (mod 2^N_BIT)
//               one CHUNK-bit slice per cycle, least-significant slice first,
//               through a single CHUNK-wide Kogge-Stone prefix carry tree.
//               Subtraction is done as op1 + ~op2 + ~borrow_in, so the slice
//               carry is an inverted borrow and is registered between slices.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               in_valid/ready   - operand handshake (accepted only in IDLE)
//               operand_1/2      - minuend / subtrahend, N_BIT wide
//               borrow_in        - incoming borrow
//               out_valid/ready  - result handshake (held in DONE)
//               difference       - N_BIT result
//               borrow_out       - unsigned borrow (op1 < op2 + borrow_in)
//               overflow         - signed overflow of the subtraction
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_tree_subtractor #(
    parameter int N_BIT = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] operand_1,
    input  logic [N_BIT-1:0] operand_2,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] difference,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int C_NCHUNK = N_BIT / CHUNK;
    localparam int C_IDX_W  = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic [N_BIT-1:0]   r_op1;
    logic [N_BIT-1:0]   r_op2n;
    logic [N_BIT-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;
    logic               r_out_valid;

    logic [CHUNK-1:0]   w_a;
    logic [CHUNK-1:0]   w_b;
    logic [CHUNK-1:0]   w_prop_bit;
    logic [CHUNK-1:0]   w_gen;
    logic [CHUNK-1:0]   w_prp;
    logic [CHUNK:0]     w_c;
    logic [CHUNK-1:0]   w_sum;

    // Slice datapath: Kogge-Stone prefix over (g,p). Walking i downward lets
    // each level be updated in place, since bit i-d still holds the previous
    // level's value when bit i is computed.
    always_comb begin
        w_a        = r_op1[r_idx*CHUNK +: CHUNK];
        w_b        = r_op2n[r_idx*CHUNK +: CHUNK];
        w_prop_bit = w_a ^ w_b;
        w_gen      = w_a & w_b;
        w_prp      = w_prop_bit;
        for (int d = 1; d < CHUNK; d = d * 2) begin
            for (int i = CHUNK - 1; i >= d; i--) begin
                w_gen[i] = w_gen[i] | (w_prp[i] & w_gen[i-d]);
                w_prp[i] = w_prp[i] & w_prp[i-d];
            end
        end
        // w_c[i] is the carry into bit i; w_c[CHUNK] is the slice carry-out.
        w_c[0] = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            w_c[i+1] = w_gen[i] | (w_prp[i] & r_carry);
        end
        w_sum = w_prop_bit ^ w_c[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_op1       <= '0;
            r_op2n      <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op1   <= operand_1;
                        r_op2n  <= ~operand_2;
                        r_carry <= ~borrow_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff[r_idx*CHUNK +: CHUNK] <= w_sum;
                    r_carry                      <= w_c[CHUNK];
                    if (r_idx == C_LAST_IDX) begin
                        // Carry out of the MSB is an inverted unsigned borrow.
                        r_borrow    <= ~w_c[CHUNK];
                        r_ovf       <= w_c[CHUNK-1] ^ w_c[CHUNK];
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + C_IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so no operands are offered while reset is held.
    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign out_valid  = r_out_valid;
    assign difference = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_tree_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_tree_subtractor
// Description : Directed self-checking bench for chunked_tree_subtractor at
//               the default 128/32 configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_tree_subtractor;

    localparam int N_BIT = 128;
    localparam int CHUNK = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N_BIT-1:0] operand_1;
    logic [N_BIT-1:0] operand_2;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [N_BIT-1:0] difference;
    logic             borrow_out;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [N_BIT-1:0] C_ONES = {N_BIT{1'b1}};
    localparam logic [N_BIT-1:0] C_MSB  = {1'b1, {(N_BIT-1){1'b0}}};

    chunked_tree_subtractor #(.N_BIT(N_BIT), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N_BIT-1:0] obs,
                       input logic [N_BIT-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE and let the next edge accept them.
    task automatic accept(input logic [N_BIT-1:0] a, input logic [N_BIT-1:0] b,
                          input logic bin);
        @(negedge clk);
        chk("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
        in_valid  = 1'b1;
        operand_1 = a;
        operand_2 = b;
        borrow_in = bin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called 1 time unit after the accept edge; result must appear after edge +4.
    task automatic expect_result(input string tag, input logic [N_BIT-1:0] d,
                                 input logic bo, input logic ov);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_early_valid"}, {127'd0, out_valid}, 128'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_valid"},      {127'd0, out_valid},  128'd1);
        chk({tag, "_difference"}, difference,           d);
        chk({tag, "_borrow_out"}, {127'd0, borrow_out}, {127'd0, bo});
        chk({tag, "_overflow"},   {127'd0, overflow},   {127'd0, ov});
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_released_valid"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_released_ready"}, {127'd0, in_ready},  128'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        borrow_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   {127'd0, in_ready},   128'd0);
        chk("rst_out_valid",  {127'd0, out_valid},  128'd0);
        chk("rst_difference", difference,           128'd0);
        chk("rst_borrow_out", {127'd0, borrow_out}, 128'd0);
        chk("rst_overflow",   {127'd0, overflow},   128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Basic with latency check
        accept(128'd5, 128'd3, 1'b0);
        expect_result("basic", 128'd2, 1'b0, 1'b0);
        release_result("basic");

        // Wrap-around and borrow_in
        accept(128'd0, 128'd1, 1'b0);
        expect_result("wrap", C_ONES, 1'b1, 1'b0);
        release_result("wrap");
        accept(128'd5, 128'd5, 1'b1);
        expect_result("bin", C_ONES, 1'b1, 1'b0);
        release_result("bin");

        // Cross-chunk borrow
        accept(128'h1_0000_0000, 128'd1, 1'b0);
        expect_result("xchunk", 128'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        release_result("xchunk");

        // Signed overflow, both directions
        accept(C_MSB, 128'd1, 1'b0);
        expect_result("ovf_neg", ~C_MSB, 1'b0, 1'b1);
        release_result("ovf_neg");
        accept(~C_MSB, C_ONES, 1'b0);
        expect_result("ovf_pos", C_MSB, 1'b1, 1'b1);
        release_result("ovf_pos");

        // Backpressure: hold DONE with new operands pending
        accept(128'd1000, 128'd1, 1'b0);
        expect_result("bp_first", 128'd999, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        operand_1 = 128'd50;
        operand_2 = 128'd8;
        borrow_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid",      {127'd0, out_valid}, 128'd1);
            chk("bp_hold_in_ready",   {127'd0, in_ready},  128'd0);
            chk("bp_hold_difference", difference,          128'd999);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_valid",    {127'd0, out_valid}, 128'd0);
        chk("bp_idle_in_ready", {127'd0, in_ready},  128'd1);
        chk("bp_idle_keep_diff", difference,         128'd999);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accepted_in_ready", {127'd0, in_ready}, 128'd0);
        expect_result("bp_second", 128'd41, 1'b0, 1'b0);
        release_result("bp_second");

        // Reset mid-RUN at the edge that would process chunk 2
        accept(C_ONES, 128'd1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid",      {127'd0, out_valid},  128'd0);
        chk("abort_difference", difference,           128'd0);
        chk("abort_borrow_out", {127'd0, borrow_out}, 128'd0);
        chk("abort_overflow",   {127'd0, overflow},   128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_pulse", {127'd0, out_valid}, 128'd0);
        end
        accept(128'd7, 128'd2, 1'b0);
        expect_result("fresh", 128'd5, 1'b0, 1'b0);
        release_result("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
